rrat_multi: RTL and testbench
=============================

Name: rrat_multi

Overview:
- Parametrised retirement register alias table (RRAT) for the out-of-order core. Holds the committed arch-to-phys register map.
- Accepts up to COMMIT_WIDTH in-order commits per cycle from the ROB head. Returns each overwritten physical register to the free list in the same cycle.
- Drives the full committed map to the front-end RAT for flush/recovery.

Parameters:
- PHYS_REG_BITS, 6, width of a physical register tag.
- NUM_ARCH_REGS, 32, number of architectural registers (power of 2, <= 2**PHYS_REG_BITS).
- COMMIT_WIDTH, 2, commit lanes per cycle. Lane 0 is oldest.
- ARCH_BITS, $clog2(NUM_ARCH_REGS), arch index width (derived; do not override).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- commit_valid  input  [COMMIT_WIDTH]  lane i retires an instruction that writes a register
- commit_rd  input  [COMMIT_WIDTH][ARCH_BITS]  arch destination per lane
- commit_pd  input  [COMMIT_WIDTH][PHYS_REG_BITS]  new physical destination per lane
- free_valid  output  [COMMIT_WIDTH]  lane i's old_pd must be enqueued to the free list this cycle
- free_pd  output  [COMMIT_WIDTH][PHYS_REG_BITS]  physical register freed by lane i
- rrat_out  output  [NUM_ARCH_REGS][PHYS_REG_BITS]  registered committed map

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- Storage: map[NUM_ARCH_REGS] of PHYS_REG_BITS. rrat_out = map, purely registered, with no same-cycle forwarding of commits.
- Reset: map[i] = i for all i, applied at the clk edge where rst=1. Commits in that cycle are discarded. Outputs during reset are combinational on the current map and inputs; bench does not check them while rst=1.
- Lane is effective iff commit_valid[i]=1 and commit_rd[i]!=0. Writes to x0 are ignored: no map update, free_valid[i]=0.
- old mapping per effective lane i:
  - If some effective lane j<i has commit_rd[j]==commit_rd[i], take the highest such j: free_pd[i]=commit_pd[j].
  - Otherwise free_pd[i]=map[commit_rd[i]].
- free_valid[i] = effective(i) AND free_pd[i]!=0. Phys 0 is the permanent x0 tag and is never freed.
- Non-effective lanes: free_valid[i]=0, free_pd[i]=0.
- Latency: free_valid/free_pd are combinational from inputs and current map, the same cycle as the commit.
- Map update at clk: for each arch register r, map[r] takes commit_pd of the highest-numbered effective lane with rd==r. Otherwise unchanged.
- Gaps are legal: any subset of lanes may be valid, e.g. lane0=0 and lane1=1.
- No backpressure: the free list is guaranteed to accept COMMIT_WIDTH enqueues per cycle.
- Checks are simulation-only assertions (not synthesised):
  - commit_pd[i]!=0 for effective lanes.
  - Two effective lanes in the same cycle must not carry identical commit_pd.

Optional Feature:
- Macro RRAT_COMMIT_CNT_EN.
- Defined:
  - Adds output commit_cnt, 32-bit, registered.
  - Adds per cycle the number of lanes with commit_valid=1, x0 lanes included.
  - Resets to 0 and wraps modulo 2**32.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset check: rst high 1 cycle -> rrat_out[i]==i for i=0..31, free_valid==0 with no commits.
- Single commit: lane0 rd=5, pd=40 -> same cycle free_valid[0]=1, free_pd[0]=5. Next cycle rrat_out[5]=40.
- Intra-group same rd: lane0 rd=7/pd=33, lane1 rd=7/pd=34, map[7]=7 -> free_pd[0]=7, free_pd[1]=33, both valid. After the edge, map[7]=34.
- x0 and gap lanes:
  - lane0 invalid, lane1 rd=0/pd=50 -> free_valid=00, map unchanged.
  - Then lane1 rd=3/pd=50 -> free_valid[1]=1, free_pd[1]=3.
- Reset mid-stream: 5 cycles of back-to-back dual commits, then rst=1 with commits valid -> next cycle map is identity and the discarded commits leave no trace. With RRAT_COMMIT_CNT_EN, commit_cnt==0.
- Counter (RRAT_COMMIT_CNT_EN): 10 cycles with both lanes valid (one with rd=0) -> commit_cnt==20.

Source files
------------

// File: rtl/rrat_multi.sv
// Retirement register alias table: committed arch-to-phys map, up to COMMIT_WIDTH in-order commits per cycle.
// Optional build macro RRAT_COMMIT_CNT_EN adds a registered 32-bit commit counter (commit_cnt).
module rrat_multi #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_ARCH_REGS = 32,
  parameter int COMMIT_WIDTH  = 2,
  localparam int ARCH_BITS    = $clog2(NUM_ARCH_REGS)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [COMMIT_WIDTH-1:0]                      commit_valid,
  input  logic [COMMIT_WIDTH-1:0][ARCH_BITS-1:0]       commit_rd,
  input  logic [COMMIT_WIDTH-1:0][PHYS_REG_BITS-1:0]   commit_pd,
  output logic [COMMIT_WIDTH-1:0]                      free_valid,
  output logic [COMMIT_WIDTH-1:0][PHYS_REG_BITS-1:0]   free_pd,
`ifdef RRAT_COMMIT_CNT_EN
  output logic [31:0]                                  commit_cnt,
`endif
  output logic [NUM_ARCH_REGS-1:0][PHYS_REG_BITS-1:0]  rrat_out
);

  logic [NUM_ARCH_REGS-1:0][PHYS_REG_BITS-1:0] map;
  logic [COMMIT_WIDTH-1:0]                     eff;

  assign rrat_out = map;

  always_comb begin
    eff = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++)
      eff[i] = commit_valid[i] && (commit_rd[i] != '0);
  end

  // An older lane in the same group writing the same rd supersedes the map entry.
  always_comb begin
    logic [PHYS_REG_BITS-1:0] old_pd;
    free_valid = '0;
    free_pd    = '0;
    old_pd     = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (eff[i]) begin
        old_pd = map[commit_rd[i]];
        for (int j = 0; j < i; j++)
          if (eff[j] && (commit_rd[j] == commit_rd[i]))
            old_pd = commit_pd[j];
        free_pd[i]    = old_pd;
        free_valid[i] = (old_pd != '0);
      end
    end
  end

  // Ascending lane order: the youngest lane's non-blocking write lands last.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++)
        map[r] <= PHYS_REG_BITS'(r);
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++)
        if (eff[i])
          map[commit_rd[i]] <= commit_pd[i];
    end
  end

`ifdef RRAT_COMMIT_CNT_EN
  // x0 lanes are counted too: this tracks retired register-writing slots.
  always_ff @(posedge clk) begin
    if (rst)
      commit_cnt <= '0;
    else
      commit_cnt <= commit_cnt + 32'($countones(commit_valid));
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (eff[i]) begin
          assert (commit_pd[i] != '0);
          for (int j = 0; j < i; j++)
            if (eff[j])
              assert (commit_pd[j] != commit_pd[i]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rrat_multi.sv
// Directed bench for rrat_multi: a sequential reference map predicts freed tags and the committed map.
// Expected free results go through exp_q and are compared when the DUT presents them.
module tb_rrat_multi;
  localparam int P  = 6;
  localparam int N  = 32;
  localparam int CW = 2;
  localparam int AB = 5;
  localparam int FW = CW + CW * P;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [CW-1:0]          commit_valid = '0;
  logic [CW-1:0][AB-1:0]  commit_rd = '0;
  logic [CW-1:0][P-1:0]   commit_pd = '0;
  logic [CW-1:0]          free_valid;
  logic [CW-1:0][P-1:0]   free_pd;
  logic [N-1:0][P-1:0]    rrat_out;
`ifdef RRAT_COMMIT_CNT_EN
  logic [31:0]            commit_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];
  logic [P-1:0]  m [N];

  always #5 clk = ~clk;

  rrat_multi #(.PHYS_REG_BITS(P), .NUM_ARCH_REGS(N), .COMMIT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .commit_valid(commit_valid),
    .commit_rd(commit_rd),
    .commit_pd(commit_pd),
    .free_valid(free_valid),
    .free_pd(free_pd),
`ifdef RRAT_COMMIT_CNT_EN
    .commit_cnt(commit_cnt),
`endif
    .rrat_out(rrat_out)
  );

  task automatic check(input string tag, input logic [N*P-1:0] obs, input logic [N*P-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*P-1:0] model_vec();
    logic [N*P-1:0] v;
    for (int i = 0; i < N; i++) v[i*P +: P] = m[i];
    return v;
  endfunction

  // One clock cycle: drive after the edge, predict, sample mid-cycle, then advance the model.
  task automatic step(input logic r, input logic [CW-1:0] v,
                      input int rd0, input int pd0, input int rd1, input int pd1);
    logic [P-1:0]         t [N];
    logic [CW-1:0]        fv;
    logic [CW-1:0][P-1:0] fp;
    logic [FW-1:0]        want;
    @(posedge clk);
    #1;
    rst          = r;
    commit_valid = v;
    commit_rd[0] = AB'(rd0);
    commit_pd[0] = P'(pd0);
    commit_rd[1] = AB'(rd1);
    commit_pd[1] = P'(pd1);
    t  = m;
    fv = '0;
    fp = '0;
    for (int i = 0; i < CW; i++) begin
      if (commit_valid[i] && commit_rd[i] != '0) begin
        fp[i] = t[commit_rd[i]];
        fv[i] = (fp[i] != '0);
        t[commit_rd[i]] = commit_pd[i];
      end
    end
    if (!r) exp_q.push_back({fv, fp});
    #3;
    if (!r) begin
      check("map", rrat_out, model_vec());
      want = exp_q.pop_front();
      check("free", {free_valid, free_pd}, want);
    end
    if (r) begin
      for (int i = 0; i < N; i++) m[i] = P'(i);
    end else begin
      m = t;
    end
  endtask

  initial begin
    int pa;
    // Reset with live commits that must be discarded.
    step(1'b1, 2'b11, 4, 10, 9, 11);
    step(1'b0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) check($sformatf("reset_id%0d", i), rrat_out[i], i);
    check("reset_fv", free_valid, 0);

    // Single commit on lane 0.
    step(1'b0, 2'b01, 5, 40, 0, 0);
    check("single_fv", free_valid, 2'b01);
    check("single_fpd0", free_pd[0], 5);
    step(1'b0, 2'b00, 0, 0, 0, 0);
    check("single_map5", rrat_out[5], 40);

    // Both lanes hit rd 7 in one group.
    step(1'b0, 2'b11, 7, 33, 7, 34);
    check("same_fv", free_valid, 2'b11);
    check("same_fpd0", free_pd[0], 7);
    check("same_fpd1", free_pd[1], 33);
    step(1'b0, 2'b00, 0, 0, 0, 0);
    check("same_map7", rrat_out[7], 34);

    // x0 write on lane 1 with a gap on lane 0, then a real write.
    step(1'b0, 2'b10, 9, 20, 0, 50);
    check("x0_fv", free_valid, 2'b00);
    step(1'b0, 2'b10, 9, 20, 3, 50);
    check("gap_fv", free_valid, 2'b10);
    check("gap_fpd1", free_pd[1], 3);
    check("gap_fpd0", free_pd[0], 0);

    // Back-to-back random dual commits, then reset while commits are valid.
    for (int k = 0; k < 5; k++) begin
      pa = $urandom_range(1, 63);
      step(1'b0, 2'b11, $urandom_range(0, 31), pa, $urandom_range(0, 31), (pa % 63) + 1);
    end
    step(1'b1, 2'b11, 12, 60, 13, 61);
    step(1'b0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < N; i += 4) check($sformatf("midrst_id%0d", i), rrat_out[i], i);
`ifdef RRAT_COMMIT_CNT_EN
    check("cnt_reset", commit_cnt, 0);
`endif

    // Both lanes valid for 10 cycles, lane 1 always writing x0.
    for (int k = 0; k < 10; k++) begin
      pa = $urandom_range(1, 63);
      step(1'b0, 2'b11, $urandom_range(1, 31), pa, 0, (pa % 63) + 1);
    end
    step(1'b0, 2'b00, 0, 0, 0, 0);
`ifdef RRAT_COMMIT_CNT_EN
    check("cnt_20", commit_cnt, 20);
`endif

    // Random mix including gaps, x0 and repeated rd.
    for (int k = 0; k < 20; k++) begin
      pa = $urandom_range(1, 63);
      step(1'b0, 2'($urandom_range(0, 3)), $urandom_range(0, 7), pa,
           $urandom_range(0, 7), (pa % 63) + 1);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
